signal_sched: RTL and testbench
===============================

# signal_sched

Round-robin scheduler that shares the single `signal` output line between the three push-button requesters `b1`, `b2`, `b3`. Each button press is synchronised, edge-detected and latched as a pending request. Requests are granted one at a time. The granted requester's identity is encoded on `signal` as a burst of 1, 2 or 3 high pulses, followed by a quiet gap. It sits between the raw button inputs and the downstream `signal` consumer, replacing direct button-to-signal logic.

## Interface
- `PULSE_LEN`, 4: cycles per high pulse and per low spacer (≥1)
- `GAP_LEN`, 8: low cycles after a burst before the next grant (≥1)
- `CNT_W`, 8: width of the pulse/gap down-counter (must hold max(PULSE_LEN, GAP_LEN)−1)

- `clk`  in  1  system clock, rising-edge
- `reset`  in  1  asynchronous, active-high reset
- `b1`, `b2`, `b3`  in  1 each  raw asynchronous button inputs (level)
- `signal`  out  1  shared encoded output line
- `grant`  out  3  one-hot current owner ({b3,b2,b1}); 0 when no owner
- `busy`  out  1  high whenever state ≠ IDLE
- `pend`  out  3  pending-request flags ({b3,b2,b1})

## Operation
- Per button: 2-flop synchroniser, then rising-edge detect (`sync2 & ~sync2_d`). An edge sets `pend[i]`.
- A held button yields exactly one request. A new edge while `pend[i]` is already 1 is dropped.
- Round-robin pointer `ptr` (0..2, reset 0 = b1 first). The winner is the first set `pend` bit searching ptr, ptr+1, ptr+2 mod 3. After granting index i, `ptr ← (i+1) mod 3`.
- FSM states are IDLE, HIGH, LOW, GAP.
  - IDLE: if `pend`≠0, on the next edge: latch winner into `grant`, clear `pend[winner]`, `left ← winner` (0/1/2), `cnt ← PULSE_LEN−1`, go to HIGH.
  - HIGH: `signal`=1. When cnt=0: if `left`=0, go to GAP with `cnt ← GAP_LEN−1`. Otherwise go to LOW with `cnt ← PULSE_LEN−1`.
  - LOW: `signal`=0. When cnt=0: `left ← left−1`, `cnt ← PULSE_LEN−1`, go to HIGH.
  - GAP: `signal`=0. When cnt=0: `grant ← 0`, go to IDLE.
  - All states: cnt decrements each cycle while cnt≠0.
- `signal` is a decode of the registered state (`state==HIGH`) and carries no combinational path from inputs.
- Burst for requester b(i+1): i+1 high pulses of PULSE_LEN cycles, separated by PULSE_LEN low cycles.

## Timing
- Reset (asynchronous, immediate): state=IDLE, `signal`=0, `grant`=0, `busy`=0, `pend`=0, `ptr`=0, cnt=0, `left`=0, synchronisers=0. Reset asserted mid-burst aborts the burst and discards all pending requests.
- Press-to-pend latency: a button high at posedge t0 gives `pend` set after posedge t2.
- Pend-to-grant: grant is taken at the first posedge in IDLE with `pend`≠0. `grant`, `busy` and `signal` all rise after that same edge.
- Service length, in cycles from grant to return to IDLE: (2k−1)·PULSE_LEN + GAP_LEN for k = i+1. With defaults: b1 = 12, b2 = 20, b3 = 28.
- Back-to-back: no idle cycle is forced beyond GAP. If `pend`≠0 at the GAP→IDLE edge, the next grant occurs one cycle later (1 IDLE cycle).
- Simultaneous set and clear of the same `pend[i]` on one edge (edge of the winner in its grant cycle): set wins, and `pend[i]` stays 1.
- An edge from the currently granted button during its own service sets `pend` and is served later under round-robin order.

## Structure
- Shared package `signal_sched_pkg`:
  - state enum (IDLE, HIGH, LOW, GAP)
  - requester index constants REQ_B1=0, REQ_B2=1, REQ_B3=2
  - NUM_REQ=3
- Sub-module `btn_sync_edge` (clk, reset, btn_in, edge_out): 2-flop synchroniser plus edge detect, instantiated three times.
- Arbiter, FSM and counters live in `signal_sched`.

## Test plan
- Single b1 press after reset (defaults): `pend`=001 after 2 edges, then `grant`=001. `signal` is high for 4 cycles, then low for 8. `busy` falls 12 cycles after grant.
- Single b3 press: `signal` sequence is 4H 4L 4H 4L 4H, then 8L. `grant`=100 for 28 cycles.
- b1, b2, b3 rising on the same edge after reset: service order b1, b2, b3. Each grant follows the previous GAP by 1 IDLE cycle. `pend` steps 111→110→100→000.
- Round-robin: press b2 and let it be served. During its burst, press b1 and b3 together. Next grant is b3 (ptr=2), then b1.
- Hold b2 high for 100 cycles: exactly one b2 burst is produced. A press of b2 again during its burst yields a second burst after the gap.
- Assert `reset` in the middle of the second HIGH pulse of a b3 burst, with `pend`=001: `signal`, `grant`, `busy` and `pend` go to 0 immediately. After deassert with no presses, the block stays idle.

Source files
------------

// File: rtl/signal_sched_pkg.sv
// Shared types and helpers for the signal_sched round-robin line scheduler.
package signal_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW,
        GAP
    } state_e;

    localparam int NUM_REQ = 3;
    localparam int REQ_B1  = 0;
    localparam int REQ_B2  = 1;
    localparam int REQ_B3  = 2;

    // First set request searching ptr, ptr+1, ptr+2 (mod NUM_REQ).
    function automatic logic [1:0] rr_pick(
        input logic [2:0] req,
        input logic [1:0] ptr
    );
        int s;
        logic [1:0] pick;
        pick = ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            s = int'(ptr) + k;
            if (s >= NUM_REQ) s = s - NUM_REQ;
            if (req[s]) pick = 2'(s);
        end
        return pick;
    endfunction

endpackage

// File: rtl/signal_sched_btn.sv
// Two-flop button synchroniser followed by a rising-edge detector.
module btn_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic edge_out
);

    logic s1_q;
    logic s2_q;
    logic s2d_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            s2d_q <= 1'b0;
        end else begin
            s1_q  <= btn_in;
            s2_q  <= s1_q;
            s2d_q <= s2_q;
        end
    end

    assign edge_out = s2_q & ~s2d_q;

endmodule

// File: rtl/signal_sched.sv
// Round-robin scheduler encoding the granted button as 1-3 pulses on signal.
module signal_sched
    import signal_sched_pkg::*;
#(
    parameter int PULSE_LEN = 4,
    parameter int GAP_LEN   = 8,
    parameter int CNT_W     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       b1,
    input  logic       b2,
    input  logic       b3,
    output logic       signal,
    output logic [2:0] grant,
    output logic       busy,
    output logic [2:0] pend
);

    localparam logic [CNT_W-1:0] PL = CNT_W'(PULSE_LEN - 1);
    localparam logic [CNT_W-1:0] GL = CNT_W'(GAP_LEN - 1);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       left_q;
    logic [1:0]       ptr_q;
    logic [2:0]       grant_q;
    logic [2:0]       pend_q;
    logic [2:0]       pend_d;
    logic [2:0]       edges;
    logic [2:0]       clr;
    logic [1:0]       win;

    btn_sync_edge u_b1 (.clk(clk), .reset(reset), .btn_in(b1), .edge_out(edges[REQ_B1]));
    btn_sync_edge u_b2 (.clk(clk), .reset(reset), .btn_in(b2), .edge_out(edges[REQ_B2]));
    btn_sync_edge u_b3 (.clk(clk), .reset(reset), .btn_in(b3), .edge_out(edges[REQ_B3]));

    assign win = rr_pick(pend_q, ptr_q);

    // A new edge on the winner in its grant cycle survives the clear.
    always_comb begin
        clr = 3'b000;
        if (state_q == IDLE && pend_q != 3'b000) clr = 3'b001 << win;
        pend_d = (pend_q & ~clr) | edges;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            left_q  <= 2'd0;
            ptr_q   <= 2'd0;
            grant_q <= 3'b000;
            pend_q  <= 3'b000;
        end else begin
            pend_q <= pend_d;
            if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
            unique case (state_q)
                IDLE: if (pend_q != 3'b000) begin
                    grant_q <= clr;
                    left_q  <= win;
                    cnt_q   <= PL;
                    ptr_q   <= (win == 2'd2) ? 2'd0 : win + 2'd1;
                    state_q <= HIGH;
                end
                HIGH: if (cnt_q == '0) begin
                    if (left_q == 2'd0) begin
                        state_q <= GAP;
                        cnt_q   <= GL;
                    end else begin
                        state_q <= LOW;
                        cnt_q   <= PL;
                    end
                end
                LOW: if (cnt_q == '0) begin
                    left_q  <= left_q - 1'b1;
                    cnt_q   <= PL;
                    state_q <= HIGH;
                end
                GAP: if (cnt_q == '0) begin
                    grant_q <= 3'b000;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign signal = (state_q == HIGH);
    assign busy   = (state_q != IDLE);
    assign grant  = grant_q;
    assign pend   = pend_q;

endmodule

// File: tb/tb_signal_sched.sv
// Randomised and directed bench for signal_sched against a timeline model.
module tb_signal_sched;

    localparam int P = 4;
    localparam int G = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] btn = 3'b000;
    logic       signal;
    logic [2:0] grant;
    logic       busy;
    logic [2:0] pend;

    int n_chk = 0;
    int n_pass = 0;

    signal_sched #(.PULSE_LEN(P), .GAP_LEN(G), .CNT_W(8)) dut (
        .clk(clk), .reset(reset),
        .b1(btn[0]), .b2(btn[1]), .b3(btn[2]),
        .signal(signal), .grant(grant), .busy(busy), .pend(pend)
    );

    always #5 clk = ~clk;

    // Model: button sample history, pending set, pointer, owner and
    // elapsed cycles into the owner's service window.
    logic [2:0] h0, h1, h2, m_pend;
    int m_ptr, m_owner, m_t;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    endtask

    function automatic int svc_len(input int i);
        return (2 * (i + 1) - 1) * P + G;
    endfunction

    task automatic model_reset();
        h0 = 0; h1 = 0; h2 = 0; m_pend = 0;
        m_ptr = 0; m_owner = -1; m_t = 0;
    endtask

    task automatic model_step(input logic [2:0] b);
        logic [2:0] e, c;
        int w;
        bit found;
        e = h1 & ~h2;
        c = 0;
        if (m_owner >= 0) begin
            m_t++;
            if (m_t == svc_len(m_owner)) m_owner = -1;
        end else if (m_pend != 0) begin
            found = 0;
            w = 0;
            for (int k = 0; k < 3; k++)
                if (!found && m_pend[(m_ptr + k) % 3]) begin
                    w = (m_ptr + k) % 3;
                    found = 1;
                end
            m_owner = w; m_t = 0;
            c[w] = 1'b1;
            m_ptr = (w + 1) % 3;
        end
        m_pend = (m_pend & ~c) | e;
        h2 = h1; h1 = h0; h0 = b;
    endtask

    task automatic compare();
        int es;
        int eg;
        es = 0;
        eg = 0;
        if (m_owner >= 0) begin
            eg = 1 << m_owner;
            if (m_t < (2 * m_owner + 1) * P && ((m_t / P) % 2) == 0) es = 1;
        end
        chk("signal", signal, es);
        chk("grant", grant, eg);
        chk("busy", busy, (m_owner >= 0) ? 1 : 0);
        chk("pend", pend, m_pend);
    endtask

    task automatic step(input logic [2:0] b);
        btn = b;
        @(posedge clk);
        model_step(b);
        #1;
        compare();
    endtask

    task automatic do_reset();
        btn = 3'b000;
        #3 reset = 1'b1;
        #1;
        chk("rst_signal", signal, 0);
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pend", pend, 0);
        model_reset();
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    int n, rises;
    logic pg;
    logic [2:0] rb;

    initial begin
        model_reset();
        #3;
        chk("init_signal", signal, 0);
        chk("init_grant", grant, 0);
        chk("init_busy", busy, 0);
        chk("init_pend", pend, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Single b1 press: latency, then 4 high + 8 low.
        step(3'b001); step(3'b001); step(3'b001);
        chk("lat_pend_b1", pend, 3'b001);
        n = 0; rises = 0;
        for (int i = 0; i < 30; i++) begin
            step(3'b000);
            if (busy) n++;
            if (signal) rises++;
        end
        chk("b1_busy_len", n, 12);
        chk("b1_high_cycles", rises, 4);

        // Single b3 press: 28 owned cycles, 12 high.
        step(3'b100); step(3'b000);
        n = 0; rises = 0;
        for (int i = 0; i < 45; i++) begin
            step(3'b000);
            if (grant == 3'b100) n++;
            if (signal) rises++;
        end
        chk("b3_grant_len", n, 28);
        chk("b3_high_cycles", rises, 12);

        // All three at once.
        step(3'b111);
        for (int i = 0; i < 80; i++) step(3'b000);
        chk("all_done", busy, 0);

        // Round-robin: b2 served, b1+b3 pressed during burst.
        step(3'b010);
        for (int i = 0; i < 6; i++) step(3'b000);
        step(3'b101);
        for (int i = 0; i < 14; i++) step(3'b000);
        n = 0;
        for (int i = 0; i < 40 && grant != 3'b100; i++) begin
            step(3'b000);
            if (grant == 3'b001) n++;
        end
        chk("rr_b3_first", grant, 3'b100);
        chk("rr_no_b1_before", n, 0);
        for (int i = 0; i < 60; i++) step(3'b000);

        // Hold b2 for 100 cycles: one burst.
        rises = 0; pg = 0;
        for (int i = 0; i < 100; i++) begin
            step(3'b010);
            if (grant[1] && !pg) rises++;
            pg = grant[1];
        end
        chk("hold_b2_bursts", rises, 1);
        for (int i = 0; i < 5; i++) step(3'b000);

        // Re-press b2 during its own burst: second burst follows.
        step(3'b010);
        for (int i = 0; i < 8; i++) step(3'b000);
        step(3'b010);
        rises = 0; pg = grant[1];
        for (int i = 0; i < 60; i++) begin
            step(3'b000);
            if (grant[1] && !pg) rises++;
            pg = grant[1];
        end
        chk("repress_b2_bursts", rises, 1);

        // Reset during second high pulse of b3 with b1 pending.
        step(3'b100); step(3'b000);
        step(3'b001);
        n = 0;
        while (!(m_owner == 2 && m_t == 2 * P + 1) && n < 40) begin
            step(3'b000);
            n++;
        end
        chk("mid_burst_reached", (n < 40) ? 1 : 0, 1);
        chk("mid_burst_pend", pend, 3'b001);
        chk("mid_burst_signal", signal, 1);
        do_reset();
        n = 0;
        for (int i = 0; i < 30; i++) begin
            step(3'b000);
            if (busy || pend != 0) n++;
        end
        chk("post_reset_idle", n, 0);

        // Random phase.
        rb = 0;
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < 3; k++)
                if ($urandom_range(0, 15) == 0) rb[k] = ~rb[k];
            if ($urandom_range(0, 699) == 0) do_reset();
            step(rb);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
